// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues SRAM reads, and buffers returned words with PC+step in a FIFO.
// Latency: a request in cycle N reaches the head in cycle N+2 when the FIFO is empty; a redirect in R puts the target at the head in R+3.
// Backpressure: out_ready low stalls pops; requests stop once count + inflight reaches DEPTH, so no fetched word is lost.
//
// Ports: clk/arst (async active-high); enable freezes requests and pops;
//        redirect_valid/redirect_pc flush the FIFO and reload the PC;
//        imem_addr/imem_ren/imem_rdata drive a synchronous SRAM (data one cycle after ren);
//        out_valid/out_instr/out_pc_next/out_ready form the head handshake; count is occupancy.
module fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     enable,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [ADDR_W-1:0]        imem_addr,
    output logic                     imem_ren,
    input  logic [DATA_W-1:0]        imem_rdata,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]        out_pc_next,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CW:0]       DEPTH_C = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] pcn_mem   [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;

    logic [CW:0]       occupancy;
    logic              req;
    logic              push;
    logic              pop;

    // The in-flight read already holds a slot, so it counts toward occupancy;
    // this is what makes overflow impossible without looking ahead at a pop.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight};
    assign req       = ~arst & enable & ~redirect_valid & (occupancy < DEPTH_C);
    // Returned data is captured even with enable low: the SRAM has already answered.
    assign push      = inflight & ~redirect_valid;
    assign pop       = (count_q != '0) & out_ready & enable & ~redirect_valid;

    assign imem_addr   = fetch_pc;
    assign imem_ren    = req;
    assign out_valid   = (count_q != '0);
    assign out_instr   = instr_mem[rd_ptr];
    assign out_pc_next = pcn_mem[rd_ptr];
    assign count       = count_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pcn_mem[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // Flush: the word returning this cycle belongs to the wrong path.
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= imem_rdata;
                pcn_mem[wr_ptr]   <= inflight_pc + STEP;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + STEP;
                inflight    <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        arst;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] imem_addr;
    logic        imem_ren;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc_next;
    logic [2:0]  count;

    logic [7:0]  w_addr;
    logic        w_ren;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [7:0]  w_pc_next;
    logic [2:0]  w_count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .arst(arst), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc_next(out_pc_next),
        .out_ready(out_ready), .count(count)
    );

    fetch_queue #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'hF8), .PC_STEP(4)) dut_w (
        .clk(clk), .arst(arst), .enable(enable),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .imem_addr(w_addr), .imem_ren(w_ren), .imem_rdata(w_rdata),
        .out_valid(w_valid), .out_instr(w_instr), .out_pc_next(w_pc_next),
        .out_ready(out_ready), .count(w_count)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM models: word at byte address a is a/4 (main), tagged address (wrap instance).
    always @(posedge clk) if (imem_ren) imem_rdata <= imem_addr >> 2;
    always @(posedge clk) if (w_ren) w_rdata <= {24'hA50000, w_addr};

    // Reference model state for the randomized test.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcn;
    } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    bit          m_inf;

    task automatic do_reset(input bit en, input bit rdy);
        arst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        enable = en;
        out_ready = rdy;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (imem_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", imem_ren); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %0h exp 0", imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (out_instr !== 32'h0 || out_pc_next !== 32'h0) begin errors++; $display("FAIL reset_head got %0h/%0h exp 0/0", out_instr, out_pc_next); end
        checks++; if (w_addr !== 8'hF8) begin errors++; $display("FAIL reset_wrap_addr got %0h exp f8", w_addr); end
    endtask

    task automatic test_free_run();
        do_reset(1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL free_first_req got %b/%0h exp 1/0", imem_ren, imem_addr); end
            end
            if (c < 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL free_early_valid c=%0d got %b exp 0", c, out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1 || out_instr !== 32'(c - 2)) begin errors++; $display("FAIL free_instr c=%0d got %b/%0h exp 1/%0h", c, out_valid, out_instr, c - 2); end
                checks++; if (out_pc_next !== 32'(4 * (c - 1))) begin errors++; $display("FAIL free_pcn c=%0d got %0h exp %0h", c, out_pc_next, 4 * (c - 1)); end
            end
        end
    endtask

    task automatic test_stall_full();
        int exp;
        do_reset(1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_count c=%0d got %0d exp 4", c, count); end
                checks++; if (imem_ren !== 1'b0) begin errors++; $display("FAIL stall_ren c=%0d got %b exp 0", c, imem_ren); end
                checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL stall_head c=%0d got %0h exp 0", c, out_instr); end
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        exp = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_instr !== 32'(exp)) begin errors++; $display("FAIL drain_instr c=%0d got %b/%0h exp 1/%0h", c, out_valid, out_instr, exp); end
            checks++; if (out_pc_next !== 32'(4 * (exp + 1))) begin errors++; $display("FAIL drain_pcn c=%0d got %0h exp %0h", c, out_pc_next, 4 * (exp + 1)); end
            exp++;
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b1);
        for (int c = 0; c < 11; c++) begin
            if (c == 5) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h40;
            end
            @(negedge clk);
            if (c == 5) begin
                checks++; if (imem_ren !== 1'b0) begin errors++; $display("FAIL redir_ren got %b exp 0", imem_ren); end
            end
            if (c == 6) begin
                checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %0d/%b exp 0/0", count, out_valid); end
                checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_req got %b/%0h exp 1/40", imem_ren, imem_addr); end
            end
            if (c == 8) begin
                checks++; if (out_valid !== 1'b1 || out_instr !== 32'h10 || out_pc_next !== 32'h44) begin errors++; $display("FAIL redir_head got %b/%0h/%0h exp 1/10/44", out_valid, out_instr, out_pc_next); end
            end
            if (c == 9) begin
                checks++; if (out_instr !== 32'h11) begin errors++; $display("FAIL redir_next got %0h exp 11", out_instr); end
            end
            @(posedge clk); #1;
            redirect_valid = 1'b0;
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL rfull_pre got %0d exp 4", count); end
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rfull_flush got %0d/%b exp 0/0", count, out_valid); end
        checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("FAIL rfull_req got %b/%0h exp 1/80", imem_ren, imem_addr); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rfull_gap got %b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h20 || out_pc_next !== 32'h84) begin errors++; $display("FAIL rfull_head got %b/%0h/%0h exp 1/20/84", out_valid, out_instr, out_pc_next); end
    endtask

    task automatic test_enable_toggle();
        int exp;
        logic [31:0] head6;
        do_reset(1'b1, 1'b1);
        exp = 0;
        head6 = '0;
        for (int c = 0; c < 16; c++) begin
            enable = !(c >= 6 && c <= 8);
            @(negedge clk);
            if (!enable) begin
                checks++; if (imem_ren !== 1'b0) begin errors++; $display("FAIL en_ren c=%0d got %b exp 0", c, imem_ren); end
                if (c == 6) head6 = out_instr;
                if (c > 6) begin
                    checks++; if (count !== 3'd2 || out_instr !== head6) begin errors++; $display("FAIL en_hold c=%0d got %0d/%0h exp 2/%0h", c, count, out_instr, head6); end
                end
            end
            if (out_valid && out_ready && enable) begin
                checks++; if (out_instr !== 32'(exp)) begin errors++; $display("FAIL en_order c=%0d got %0h exp %0h", c, out_instr, exp); end
                exp++;
            end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        checks++; if (exp != 11) begin errors++; $display("FAIL en_pops got %0d exp 11", exp); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 3) begin
                checks++; if (w_ren !== 1'b1 || w_addr !== 8'(8'hF8 + 4 * c)) begin errors++; $display("FAIL wrap_addr c=%0d got %b/%0h exp 1/%0h", c, w_ren, w_addr, 8'(8'hF8 + 4 * c)); end
            end
            if (c >= 2) begin
                checks++; if (w_valid !== 1'b1 || w_instr !== {24'hA50000, 8'(8'hF8 + 4 * (c - 2))}) begin errors++; $display("FAIL wrap_instr c=%0d got %b/%0h", c, w_valid, w_instr); end
                checks++; if (w_pc_next !== 8'(8'hFC + 4 * (c - 2))) begin errors++; $display("FAIL wrap_pcn c=%0d got %0h exp %0h", c, w_pc_next, 8'(8'hFC + 4 * (c - 2))); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_pre got %0d exp 3", count); end
        #1 arst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rmid_clear got %b/%0d exp 0/0", out_valid, count); end
        checks++; if (imem_addr !== 32'h0 || imem_ren !== 1'b0) begin errors++; $display("FAIL rmid_addr got %0h/%b exp 0/0", imem_addr, imem_ren); end
        checks++; if (w_addr !== 8'hF8) begin errors++; $display("FAIL rmid_wrap got %0h exp f8", w_addr); end
    endtask

    task automatic test_random();
        bit exp_ren;
        bit popd;
        do_reset(1'b1, 1'b1);
        m_q.delete();
        m_pc = 32'h0;
        m_ifpc = 32'h0;
        m_inf = 1'b0;
        for (int n = 0; n < 500; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = 32'($urandom_range(0, 255)) << 2;
            @(negedge clk);
            exp_ren = enable && !redirect_valid && (m_q.size() + int'(m_inf) < DEPTH);
            checks++; if (imem_ren !== exp_ren || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_req n=%0d got %b/%0h exp %b/%0h", n, imem_ren, imem_addr, exp_ren, m_pc); end
            checks++; if (count !== 3'(m_q.size()) || out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_count n=%0d got %0d/%b exp %0d", n, count, out_valid, m_q.size()); end
            if (m_q.size() != 0) begin
                checks++; if (out_instr !== m_q[0].instr || out_pc_next !== m_q[0].pcn) begin errors++; $display("FAIL rnd_head n=%0d got %0h/%0h exp %0h/%0h", n, out_instr, out_pc_next, m_q[0].instr, m_q[0].pcn); end
            end
            @(posedge clk);
            if (redirect_valid) begin
                m_q.delete();
                m_inf = 1'b0;
                m_pc = redirect_pc;
            end else begin
                popd = (m_q.size() != 0) && out_ready && enable;
                if (popd) void'(m_q.pop_front());
                if (m_inf) m_q.push_back('{m_ifpc >> 2, m_ifpc + 32'd4});
                if (exp_ren) begin
                    m_ifpc = m_pc;
                    m_pc = m_pc + 32'd4;
                    m_inf = 1'b1;
                end else begin
                    m_inf = 1'b0;
                end
            end
            #1;
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall_full();
        test_redirect();
        test_redirect_full();
        test_enable_toggle();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
